// File: rtl/move_sequencer_pkg.sv
// Shared solver definitions: FSM states, saturation bounds, index LFSR constants.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package move_sequencer_pkg;

  // Move sequencer control states, in the order a move walks through them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REDUCE = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Default block geometry.
  localparam int DEF_COEF_W        = 8;
  localparam int DEF_VAR_IDX_W     = 2;
  localparam int DEF_VAR_W         = 4;
  localparam int DEF_CLAUSE_IDX_W  = 3;
  localparam int DEF_PROPOSE_LAT   = 3;

  // Proposals are compared as 32-bit signed integers before clamping.
  localparam int SAT_CMP_W = 32;

  // 16-bit maximal LFSR, x^16+x^14+x^13+x^11+1, right-shifting form:
  // feedback is the XOR of bits 0,2,3,5 and enters at bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Largest value representable in a signed field of the given width.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Bundles the move sequencer's control, memory, proposer and assignment signals.
// Latency: none (wiring only).
// Backpressure: none; the sequencer side reports progress through out_busy/out_done.
interface move_sequencer_if #(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
  parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   = 4,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 3
) ();

  localparam int W = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
  localparam int N = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
  localparam int V = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int C = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;

  logic                        in_start;
  logic [C:0]                  in_num_clauses;
  logic                        in_load_assignment;
  logic [V*(2**N)-1:0]         in_initial_assignment;
  logic [C-1:0]                out_mem_addr;
  logic [(2**N+1)*W-1:0]       in_mem_data;
  logic [(2**N+1)*W-1:0]       out_clause_coefficients;
  logic [C-1:0]                out_clause_index;
  logic [N-1:0]                out_variable_index;
  logic [2**C-1:0]             out_reduce_enable;
  logic signed [W-1:0]         in_new_assignment;
  logic [V*(2**N)-1:0]         out_assignment;
  logic                        out_busy;
  logic                        out_done;

  // Sequencer side.
  modport slave (
    input  in_start, in_num_clauses, in_load_assignment, in_initial_assignment,
    input  in_mem_data, in_new_assignment,
    output out_mem_addr, out_clause_coefficients, out_clause_index,
    output out_variable_index, out_reduce_enable, out_assignment,
    output out_busy, out_done
  );

  // Controller / environment side.
  modport master (
    output in_start, in_num_clauses, in_load_assignment, in_initial_assignment,
    output in_mem_data, in_new_assignment,
    input  out_mem_addr, out_clause_coefficients, out_clause_index,
    input  out_variable_index, out_reduce_enable, out_assignment,
    input  out_busy, out_done
  );

endinterface

// File: rtl/move_sequencer_variable_index_generator.sv
// Picks the variable left free for each move: LFSR low bits when MOVE_SEQUENCER_LFSR_EN is defined, else round-robin.
// Latency: o_index is valid combinationally from state; advances one cycle after i_step.
// Backpressure: none; steps exactly once per cycle that i_step is high.
module variable_index_generator
  import move_sequencer_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  output logic [IDX_W-1:0] o_index
);

`ifdef MOVE_SEQUENCER_LFSR_EN
  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = ^(r_lfsr & LFSR_TAPS);

  // Advance the LFSR once per accepted move; reset reloads the seed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_lfsr <= LFSR_SEED;
    else if (i_step)
      r_lfsr <= {w_feedback, r_lfsr[15:1]};
  end

  assign o_index = r_lfsr[IDX_W-1:0];
`else
  logic [IDX_W-1:0] r_count;

  // Round-robin through every variable, wrapping naturally at 2**IDX_W.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_count <= '0;
    else if (i_step)
      r_count <= r_count + IDX_W'(1);
  end

  assign o_index = r_count;
`endif

endmodule

// File: rtl/move_sequencer.sv
// One local-search move: stream clause memory to the proposer, reduce, then commit a saturated value (index source: MOVE_SEQUENCER_LFSR_EN).
// Latency: start accepted at edge k gives out_done in cycle k + 2**C + PROPOSE_LATENCY + 3.
// Backpressure: none; in_start/in_load_assignment are only honoured in IDLE, out_busy flags a move in flight.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = DEF_COEF_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = DEF_VAR_IDX_W,
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   = DEF_VAR_W,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = DEF_CLAUSE_IDX_W,
  parameter int PROPOSE_LATENCY                     = DEF_PROPOSE_LAT
) (
  input  logic            in_clk,
  input  logic            in_reset,
  move_sequencer_if.slave bus
);

  localparam int N           = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
  localparam int V           = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int C           = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int NUM_VARS    = 2**N;
  localparam int NUM_CLAUSES = 2**C;
  // One counter times both LOAD (needs 0..2**C) and REDUCE (needs 0..14).
  localparam int CNT_W       = (C + 1 > 4) ? C + 1 : 4;

  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(NUM_CLAUSES);
  localparam logic [CNT_W-1:0] ADDR_LAST   = CNT_W'(NUM_CLAUSES - 1);
  localparam logic [CNT_W-1:0] REDUCE_LAST = CNT_W'(PROPOSE_LATENCY - 1);
  localparam int               SAT_HI      = sat_max(V);
  localparam int               SAT_LO      = sat_min(V);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W-1:0]        r_phase_cnt;
  logic [C-1:0]            r_mem_addr;
  logic [C-1:0]            r_clause_index;
  logic [N-1:0]            r_var_idx;
  logic [N-1:0]            w_gen_idx;
  logic [V*NUM_VARS-1:0]   r_assignment;
  logic                    w_accept_start;
  logic                    w_load_vld;
  logic                    w_commit_wr;
  logic [NUM_CLAUSES-1:0]  w_clause_mask;
  logic signed [SAT_CMP_W-1:0] w_new_int;
  logic [V-1:0]            w_sat_value;

  assign w_accept_start = (r_state == ST_IDLE) && bus.in_start;
  // Memory data lags the address by one cycle, so the first LOAD cycle carries no word.
  assign w_load_vld     = (r_state == ST_LOAD) && (r_phase_cnt != '0);
  // With no active clauses the proposal is meaningless; skip the write.
  assign w_commit_wr    = (r_state == ST_COMMIT) && (bus.in_num_clauses != '0);

  variable_index_generator #(
    .IDX_W (N)
  ) u_index_gen (
    .i_clk   (in_clk),
    .i_rst_n (in_reset),
    .i_step  (w_accept_start),
    .o_index (w_gen_idx)
  );

  // State register.
  always_ff @(posedge in_clk) begin
    if (!in_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  // Next-state selection; LOAD and REDUCE end on phase-counter terminal counts.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (bus.in_start) w_next_state = ST_LOAD;
      ST_LOAD:   if (r_phase_cnt == LOAD_LAST) w_next_state = ST_REDUCE;
      ST_REDUCE: if (r_phase_cnt == REDUCE_LAST) w_next_state = ST_COMMIT;
      ST_COMMIT: w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Phase counter restarts at 0 on every state change and counts cycles within the state.
  always_ff @(posedge in_clk) begin
    if (!in_reset)
      r_phase_cnt <= '0;
    else if (w_next_state != r_state)
      r_phase_cnt <= '0;
    else if (r_state != ST_IDLE)
      r_phase_cnt <= r_phase_cnt + CNT_W'(1);
  end

  // Clause memory address walks 0..2**C-1 during LOAD, then holds.
  always_ff @(posedge in_clk) begin
    if (!in_reset)
      r_mem_addr <= '0;
    else if (w_accept_start)
      r_mem_addr <= '0;
    else if ((r_state == ST_LOAD) && (r_phase_cnt < ADDR_LAST))
      r_mem_addr <= r_mem_addr + C'(1);
  end

  // Clause index trails the address by one cycle to line up with the returned word.
  always_ff @(posedge in_clk) begin
    if (!in_reset)
      r_clause_index <= '0;
    else if ((r_state == ST_LOAD) && (r_phase_cnt <= ADDR_LAST))
      r_clause_index <= r_mem_addr;
  end

  // Free variable is captured as the move leaves IDLE and held until the next move.
  always_ff @(posedge in_clk) begin
    if (!in_reset)
      r_var_idx <= '0;
    else if (w_accept_start)
      r_var_idx <= w_gen_idx;
  end

  // Clause i participates in the reduction only when it is below the active count.
  always_comb begin
    w_clause_mask = '0;
    for (int i = 0; i < NUM_CLAUSES; i++)
      w_clause_mask[i] = (i < int'(bus.in_num_clauses));
  end

  // Clamp the signed proposal into the signed V-bit variable range.
  always_comb begin
    w_new_int = SAT_CMP_W'(bus.in_new_assignment);
    if (w_new_int > SAT_HI)
      w_sat_value = V'(SAT_HI);
    else if (w_new_int < SAT_LO)
      w_sat_value = V'(SAT_LO);
    else
      w_sat_value = w_new_int[V-1:0];
  end

  // Assignment register: bulk load in IDLE, single-slot write in COMMIT.
  always_ff @(posedge in_clk) begin
    if (!in_reset)
      r_assignment <= '0;
    else if ((r_state == ST_IDLE) && bus.in_load_assignment)
      r_assignment <= bus.in_initial_assignment;
    else if (w_commit_wr)
      r_assignment[int'(r_var_idx) * V +: V] <= w_sat_value;
  end

  assign bus.out_mem_addr            = r_mem_addr;
  assign bus.out_clause_coefficients = w_load_vld ? bus.in_mem_data : '0;
  assign bus.out_clause_index        = r_clause_index;
  assign bus.out_variable_index      = r_var_idx;
  assign bus.out_reduce_enable       = (r_state == ST_REDUCE) ? w_clause_mask : '0;
  assign bus.out_assignment          = r_assignment;
  assign bus.out_busy                = (r_state != ST_IDLE);
  assign bus.out_done                = (r_state == ST_DONE);

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer at default geometry (round-robin index build).
// Latency: expects out_done 14 cycles after the accepting edge.
// Backpressure: drives stray in_start/in_load_assignment mid-move and expects them ignored.
`timescale 1ns/1ps
module tb_move_sequencer;
  import move_sequencer_pkg::*;

  localparam int W   = 8;
  localparam int N   = 2;
  localparam int V   = 4;
  localparam int C   = 3;
  localparam int PL  = 3;
  localparam int LAT = 14;

  typedef struct packed {
    logic [1:0]  idx;
    logic [7:0]  mask;
    logic [15:0] asg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb_q[$];
  logic [15:0] model_assign = '0;
  int   model_rr = 0;

  always #5 clk = ~clk;

  move_sequencer_if #(
    .MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    (W),
    .MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX (N),
    .MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   (V),
    .MAX_BIT_WIDTH_OF_CLAUSES_INDEX      (C)
  ) bus ();

  move_sequencer #(
    .MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    (W),
    .MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX (N),
    .MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   (V),
    .MAX_BIT_WIDTH_OF_CLAUSES_INDEX      (C),
    .PROPOSE_LATENCY                     (PL)
  ) dut (
    .in_clk   (clk),
    .in_reset (rst_n),
    .bus      (bus)
  );

  // Clause memory: one-cycle read latency, word at address a is byte a replicated.
  logic [7:0] addr_byte;
  assign addr_byte = 8'(bus.out_mem_addr);
  always @(posedge clk) bus.in_mem_data <= {5{addr_byte}};

  function automatic logic [3:0] sat4(input int v);
    logic [31:0] t;
    if (v > 7) return 4'd7;
    if (v < -8) return 4'b1000;
    t = v;
    return t[3:0];
  endfunction

  function automatic logic [7:0] mask_of(input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i] = (i < n);
    return m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_start = 1'b1;
    bus.in_num_clauses = 4'd5;
    bus.in_load_assignment = 1'b1;
    bus.in_initial_assignment = 16'hBEEF;
    bus.in_new_assignment = 8'sd1;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.out_busy); else passed++;
    checks++; if (bus.out_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.out_done); else passed++;
    checks++; if (bus.out_assignment !== 16'h0) $display("FAIL reset_assign got=%h exp=0000", bus.out_assignment); else passed++;
    checks++; if (bus.out_variable_index !== 2'd0) $display("FAIL reset_varidx got=%0d exp=0", bus.out_variable_index); else passed++;
    checks++; if (bus.out_reduce_enable !== 8'h0) $display("FAIL reset_reduce got=%b exp=0", bus.out_reduce_enable); else passed++;
    checks++; if (bus.out_mem_addr !== 3'd0) $display("FAIL reset_memaddr got=%0d exp=0", bus.out_mem_addr); else passed++;
    checks++; if (bus.out_clause_index !== 3'd0) $display("FAIL reset_clidx got=%0d exp=0", bus.out_clause_index); else passed++;
    checks++; if (bus.out_clause_coefficients !== 40'h0) $display("FAIL reset_coef got=%h exp=0", bus.out_clause_coefficients); else passed++;
    bus.in_start = 1'b0;
    bus.in_load_assignment = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full move with per-cycle checks; expectations go through the scoreboard.
  task automatic run_move(input int ncl, input int newval, input logic do_load, input logic [15:0] init);
    exp_t e;
    exp_t popped;
    int   done_seen;
    logic [7:0]  b;
    logic [7:0]  exp_red;
    logic [39:0] exp_coef;
    @(negedge clk);
    bus.in_num_clauses = 4'(ncl);
    bus.in_new_assignment = 8'(newval);
    bus.in_load_assignment = do_load;
    bus.in_initial_assignment = init;
    bus.in_start = 1'b1;
    if (do_load) model_assign = init;
    e.idx = 2'(model_rr);
    model_rr = (model_rr + 1) % 4;
    e.mask = mask_of(ncl);
    if (ncl != 0) model_assign[int'(e.idx) * 4 +: 4] = sat4(newval);
    e.asg = model_assign;
    sb_q.push_back(e);
    popped = e;
    done_seen = 0;
    for (int j = 1; j <= LAT + 1; j++) begin
      @(negedge clk);
      if (j == 1) begin
        checks++; if (bus.out_variable_index !== e.idx) $display("FAIL varidx got=%0d exp=%0d", bus.out_variable_index, e.idx); else passed++;
        checks++; if (bus.out_busy !== 1'b1) $display("FAIL busy_start got=%b exp=1", bus.out_busy); else passed++;
        if (do_load) begin
          checks++; if (bus.out_assignment !== init) $display("FAIL load_assign got=%h exp=%h", bus.out_assignment, init); else passed++;
        end
        bus.in_start = 1'b0;
        bus.in_load_assignment = 1'b0;
      end
      if (j == 4) bus.in_start = 1'b1;
      if (j == 5) begin
        bus.in_start = 1'b0;
        bus.in_load_assignment = 1'b1;
        bus.in_initial_assignment = 16'hFFFF;
      end
      if (j == 6) bus.in_load_assignment = 1'b0;
      if (j >= 2 && j <= 9) begin
        b = 8'(j - 2);
        exp_coef = {5{b}};
        checks++; if (bus.out_clause_index !== b[2:0]) $display("FAIL bus_index j=%0d got=%0d exp=%0d", j, bus.out_clause_index, b[2:0]); else passed++;
        checks++; if (bus.out_clause_coefficients !== exp_coef) $display("FAIL bus_coef j=%0d got=%h exp=%h", j, bus.out_clause_coefficients, exp_coef); else passed++;
      end
      if (j == 10) begin
        checks++; if (bus.out_clause_index !== 3'd7) $display("FAIL hold_index got=%0d exp=7", bus.out_clause_index); else passed++;
        checks++; if (bus.out_clause_coefficients !== 40'h0) $display("FAIL idle_coef got=%h exp=0", bus.out_clause_coefficients); else passed++;
      end
      exp_red = (j >= 10 && j <= 12) ? e.mask : 8'h0;
      checks++; if (bus.out_reduce_enable !== exp_red) $display("FAIL reduce j=%0d got=%b exp=%b", j, bus.out_reduce_enable, exp_red); else passed++;
      if (bus.out_done === 1'b1) begin
        done_seen++;
        checks++;
        if (sb_q.size() == 0) $display("FAIL done_extra j=%0d got=1 exp=0", j);
        else begin
          popped = sb_q.pop_front();
          if (j !== LAT) $display("FAIL done_cycle got=%0d exp=%0d", j, LAT); else passed++;
          checks++; if (bus.out_variable_index !== popped.idx) $display("FAIL done_varidx got=%0d exp=%0d", bus.out_variable_index, popped.idx); else passed++;
        end
      end
      if (j == LAT + 1) begin
        checks++; if (bus.out_busy !== 1'b0) $display("FAIL busy_end got=%b exp=0", bus.out_busy); else passed++;
        checks++; if (bus.out_assignment !== popped.asg) $display("FAIL commit_assign got=%h exp=%h", bus.out_assignment, popped.asg); else passed++;
      end
    end
    if (done_seen == 0) begin
      checks++;
      $display("FAIL done_missing got=0 pulses exp=1");
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
  endtask

  task automatic test_round_robin();
    run_move(5, 100, 1'b0, 16'h0);
    run_move(5, -100, 1'b0, 16'h0);
    run_move(5, 3, 1'b0, 16'h0);
    run_move(5, -2, 1'b0, 16'h0);
    run_move(5, 50, 1'b0, 16'h0);
  endtask

  task automatic test_zero_clauses();
    run_move(0, -5, 1'b0, 16'h0);
  endtask

  task automatic test_load_with_start();
    run_move(8, -1, 1'b1, 16'h1234);
  endtask

  task automatic test_reset_mid_move();
    int done_cnt;
    @(negedge clk);
    bus.in_num_clauses = 4'd5;
    bus.in_new_assignment = 8'sd100;
    bus.in_start = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      bus.in_start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.out_busy); else passed++;
    checks++; if (bus.out_assignment !== 16'h0) $display("FAIL midrst_assign got=%h exp=0000", bus.out_assignment); else passed++;
    checks++; if (bus.out_reduce_enable !== 8'h0) $display("FAIL midrst_reduce got=%b exp=0", bus.out_reduce_enable); else passed++;
    checks++; if (bus.out_variable_index !== 2'd0) $display("FAIL midrst_varidx got=%0d exp=0", bus.out_variable_index); else passed++;
    rst_n = 1'b1;
    model_assign = '0;
    model_rr = 0;
    done_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      if (bus.out_done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    checks++; if (done_cnt !== 0) $display("FAIL midrst_done got=%0d pulses exp=0", done_cnt); else passed++;
  endtask

  task automatic test_after_reset();
    run_move(2, 5, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_zero_clauses();
    test_load_with_start();
    test_reset_mid_move();
    test_after_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, default 8: coefficient, bias and proposed-value width.
REQ-002 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX, default 2: 2**N integer variables.
REQ-003 SHALL have parameter MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, default 4: stored assignment width per variable.
REQ-004 SHALL have parameter MAX_BIT_WIDTH_OF_CLAUSES_INDEX, default 3: 2**C clause slots.
REQ-005 SHALL have parameter PROPOSE_LATENCY, default 3: cycles from reduce enable to a valid proposal, legal range 1..15.
REQ-006 in_clk  input  1  single clock; all logic on rising edge.
REQ-007 in_reset  input  1  synchronous, active-low reset.
REQ-008 in_start  input  1  request one move; sampled only in IDLE.
REQ-009 in_num_clauses  input  C+1  number of active clauses, 0..2**C.
REQ-010 in_load_assignment  input  1  load in_initial_assignment; honoured only in IDLE.
REQ-011 in_initial_assignment  input  V*2**N  packed assignment, variable 0 in LSBs.
REQ-012 out_mem_addr  output  C  clause memory read address; memory read latency 1 cycle.
REQ-013 in_mem_data  input  (2**N+1)*W  clause coefficients plus bias from memory.
REQ-014 out_clause_coefficients / out_clause_index  output  (2**N+1)*W / C  clause register write bus to the proposer.
REQ-015 out_variable_index  output  N  variable held free for this move.
REQ-016 out_reduce_enable  output  2**C  per-clause reduce enable.
REQ-017 in_new_assignment  input  W signed  proposed corner value from the proposer.
REQ-018 out_assignment  output  V*2**N  current assignment register.
REQ-019 out_busy / out_done  output  1 / 1  not IDLE / one-cycle move-complete pulse.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, REDUCE, COMMIT, DONE.
REQ-021 IDLE->LOAD on in_start=1; in_start in any other state SHALL be ignored.
REQ-022 On leaving IDLE, out_variable_index SHALL latch the next index and hold it until the following IDLE.
REQ-023 LOAD SHALL issue addresses 0..2**C-1 on consecutive cycles; each returned word SHALL be presented one cycle later on out_clause_coefficients with out_clause_index equal to its address; LOAD lasts 2**C+1 cycles.
REQ-024 Outside LOAD, out_clause_index SHALL hold its last value and out_clause_coefficients SHALL drive zero.
REQ-025 REDUCE SHALL last PROPOSE_LATENCY cycles with out_reduce_enable[i]=1 exactly for i<in_num_clauses, and all zero in every other state.
REQ-026 COMMIT (1 cycle) SHALL write in_new_assignment into the out_assignment slot out_variable_index, saturated to the signed V-bit range; other slots SHALL remain unchanged.
REQ-027 in_num_clauses=0: FSM SHALL pass through all states with no write in COMMIT.
REQ-028 DONE SHALL assert out_done for exactly one cycle, then return to IDLE.
REQ-029 Latency: in_start sampled at edge k SHALL give out_done high in cycle k+2**C+PROPOSE_LATENCY+3 (k+14 at defaults).
REQ-030 in_load_assignment in IDLE SHALL replace out_assignment at the next edge; if coincident with in_start, the load SHALL occur and the move SHALL then start.

Reset
REQ-031 in_reset=0 at any edge SHALL force IDLE, clear out_assignment, out_clause_coefficients, out_clause_index, out_mem_addr, out_variable_index, out_reduce_enable, out_busy and out_done to 0, and seed the index generator; any move in progress SHALL be abandoned without a commit.

Configuration
REQ-032 With MOVE_SEQUENCER_LFSR_EN defined, the next variable index SHALL be the low N bits of a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, stepped once per accepted start).
REQ-033 Without MOVE_SEQUENCER_LFSR_EN, the next variable index SHALL be a round-robin counter: 0,1,...,2**N-1,0.

Structure
REQ-034 The FSM state enum, the saturation width constants and the LFSR seed/taps SHALL live in the shared solver package.
REQ-035 The index generator SHALL be a single sub-module, variable_index_generator, holding both the LFSR and the counter variants.

Verification
REQ-036 Reset then in_start with round-robin build -> out_variable_index 0,1,2,3,0 over five moves; out_done at k+14 each time.
REQ-037 in_num_clauses=5 -> out_reduce_enable=8'b0001_1111 for 3 cycles in REDUCE, 0 at all other times.
REQ-038 in_new_assignment=+100, V=4 -> slot holds 4'sd7; in_new_assignment=-100 -> slot holds -4'sd8 (4'b1000).
REQ-039 in_load_assignment=1 with in_initial_assignment=16'h1234 and in_start in the same cycle -> out_assignment=16'h1234, then the move commits into the selected slot only.
REQ-040 in_reset=0 asserted during REDUCE -> next cycle IDLE, out_assignment=0, no out_done pulse.
REQ-041 LOAD with memory word at address a = {a replicated} -> write bus shows address a at cycle k+2+a, index matching the data.
